irrigation_countdown_timer: RTL and testbench
=============================================

Name: irrigation_countdown_timer

Overview:
- BCD countdown timer that produces the mm:ss digits monitored by the timer reset generator in the irrigation subsystem.
- While `reset` is high, the block holds and presents the irrigation duration for the selected mode.
- After `reset` releases, it counts down once per `tick` to 00:00.
- It then signals `done` and holds 00:00, which makes the reset generator re-arm it through `reset`.

Parameters:
- SPRINKLER_MIN, default 5: sprinkler-mode duration in whole minutes, range 1..39.
- DRIP_MIN, default 30: drip-mode duration in whole minutes, range 1..39.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; forces state LOAD.
- tick  in  1  one-clock-wide 1 Hz enable from the prescaler.
- splinker_mode_on  in  1  1 = sprinkler duration, 0 = drip duration; sampled only in LOAD.
- seconds_u  out  4  seconds units, BCD 0..9.
- seconds_d  out  3  seconds tens, 0..5.
- minutes_u  out  4  minutes units, BCD 0..9.
- minutes_d  out  2  minutes tens, 0..3.
- running  out  1  high in state RUN.
- done  out  1  one-clock pulse on arrival at 00:00.

Behaviour:
- Clock and reset: one clock domain. `reset` is asynchronous and active-high. It forces the state to LOAD immediately and clears `done` and `running` to 0.
- Preset digits:
  - Derived at elaboration from the selected minutes parameter (tens = M/10, units = M%10).
  - Seconds digits are always 0.
- State LOAD (entered on reset):
  - Digit outputs are combinationally driven from the preset selected by the live `splinker_mode_on`. This ensures the digits are never 00:00 while reset is held, so the reset generator's zero detect cannot lock up.
  - Every clock, the internal digit registers load that same preset.
  - First clock edge with `reset` low → RUN. No decrement occurs on that edge, even if `tick` is high.
- State RUN:
  - Digit outputs come from the registers; `running` = 1.
  - On `tick` = 1, decrement mm:ss by one second using a borrow chain:
    - seconds_u: 0 → 9, borrow.
    - seconds_d: 0 → 5, borrow.
    - minutes_u: 0 → 9, borrow.
    - minutes_d: decrement.
  - A digit changes only when `tick` is high and it is 0 with a borrow in, or nonzero with a borrow in. seconds_u always has a borrow in on a tick.
  - If the decrement yields 00:00 → DONE. `done` = 1 for exactly the clock cycle after that edge.
  - `tick` = 0 holds all digits.
- State DONE:
  - Digits hold 00:00; `running` = 0; `tick` is ignored.
  - Exit only via `reset`; the reset generator asserts it because the digits read zero.
- Mode changes during RUN or DONE have no effect until the next LOAD.
- Reset mid-RUN: asynchronously abandons the count. Outputs show the current-mode preset within the same cycle.
- Registers never hold illegal BCD values. Any illegal code detected (for example after an upset) forces DONE on the next edge.

Decomposition:
- Shared package `irrigation_timer_pkg`:
  - State encoding: LOAD=2'b00, RUN=2'b01, DONE=2'b10.
  - Digit width constants: 4/3/4/2.
  - Function `min_to_bcd(M)` returning tens/units.
- One sub-module, `bcd_down_digit`:
  - Parameters: WIDTH, MAX.
  - Inputs: clock, reset, load, load_val, borrow_in.
  - Outputs: value, borrow_out (value==0 && borrow_in).
  - Instantiated four times in a chain.
- Top level holds the FSM and the preset/zero logic.

Test Plan:
- Hold reset with splinker_mode_on=1 (defaults) → outputs 05:00, running=0. Release reset, apply 1 tick → 04:59, running=1.
- Sprinkler run to completion: 300 ticks after release → 00:00 reached on the 300th tick; done high for exactly 1 cycle, running=0. Digits stay 00:00 for 10 further ticks.
- Drip mode with borrow across every digit: load 30:00, apply 1 tick → 29:59; apply 540 more → 20:59; check seconds_d wraps 0→5 and minutes_u wraps 0→9.
- Reset mid-run: at 12:34 in drip mode, assert reset asynchronously between edges → digits 30:00 immediately, running=0, no done pulse.
- Mode change during RUN: toggle splinker_mode_on at 03:10 → count continues unchanged. After the next reset the preset follows the new mode.
- Tick coincident with the LOAD→RUN edge → no decrement (preset held). A tick held low for 100 cycles in RUN → digits unchanged.

Source files
------------

// File: rtl/irrigation_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : irrigation_timer_pkg
//  Purpose  : Shared types and constants for the irrigation countdown timer:
//             FSM state encoding, BCD digit widths/limits and a helper that
//             splits a whole-minute count into tens/units BCD digits.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package irrigation_timer_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Digit widths: seconds units / seconds tens / minutes units / minutes tens
    localparam int C_SEC_U_W = 4;
    localparam int C_SEC_D_W = 3;
    localparam int C_MIN_U_W = 4;
    localparam int C_MIN_D_W = 2;

    // Largest legal value of each digit
    localparam int C_SEC_U_MAX = 9;
    localparam int C_SEC_D_MAX = 5;
    localparam int C_MIN_U_MAX = 9;
    localparam int C_MIN_D_MAX = 3;

    typedef struct packed {
        logic [C_MIN_D_W-1:0] tens;
        logic [C_MIN_U_W-1:0] units;
    } bcd_min_t;

    // Whole minutes (1..39) to BCD tens/units
    function automatic bcd_min_t min_to_bcd(input int unsigned m);
        bcd_min_t r;
        r.tens  = C_MIN_D_W'(m / 10);
        r.units = C_MIN_U_W'(m % 10);
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_down_digit.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_down_digit
//  Purpose  : One down-counting BCD digit of a borrow chain. Wraps 0 -> MAX
//             and raises borrow_out when it wraps.
//  Ports    : clock, reset (async, active-high)
//             load/load_val  - synchronous load, has priority over counting
//             borrow_in      - decrement request from the lower digit
//             value          - current digit
//             borrow_out     - value==0 && borrow_in
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_down_digit #(
    parameter int WIDTH = 4,
    parameter int MAX   = 9
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             borrow_in,
    output logic [WIDTH-1:0] value,
    output logic             borrow_out
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_val;
        end else if (borrow_in) begin
            value_d = (value_q == '0) ? WIDTH'(MAX) : (value_q - WIDTH'(1));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value      = value_q;
    assign borrow_out = (value_q == '0) && borrow_in;

endmodule
`default_nettype wire

// File: rtl/irrigation_countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module   : irrigation_countdown_timer
//  Purpose  : mm:ss BCD countdown for the irrigation subsystem. Presents the
//             mode preset while in LOAD, counts down one second per tick in
//             RUN, pulses done and holds 00:00 in DONE until reset.
//  Ports    : clock, reset (async, active-high), tick (1 Hz enable),
//             splinker_mode_on (1 = sprinkler, 0 = drip),
//             seconds_u/seconds_d/minutes_u/minutes_d (BCD digits),
//             running (state RUN), done (one-cycle pulse on reaching 00:00)
//  Revision : 1.0 - initial release
// ============================================================================
module irrigation_countdown_timer
    import irrigation_timer_pkg::*;
#(
    parameter int SPRINKLER_MIN = 5,
    parameter int DRIP_MIN      = 30
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 splinker_mode_on,
    output logic [C_SEC_U_W-1:0] seconds_u,
    output logic [C_SEC_D_W-1:0] seconds_d,
    output logic [C_MIN_U_W-1:0] minutes_u,
    output logic [C_MIN_D_W-1:0] minutes_d,
    output logic                 running,
    output logic                 done
);

    localparam bcd_min_t C_SPR_PRESET  = min_to_bcd(SPRINKLER_MIN);
    localparam bcd_min_t C_DRIP_PRESET = min_to_bcd(DRIP_MIN);

    state_t   state_q, state_d;
    logic     done_q, done_d;
    bcd_min_t w_preset;

    logic [C_SEC_U_W-1:0] w_su;
    logic [C_SEC_D_W-1:0] w_sd;
    logic [C_MIN_U_W-1:0] w_mu;
    logic [C_MIN_D_W-1:0] w_md;
    logic w_su_borrow, w_sd_borrow, w_mu_borrow, w_md_borrow;
    logic w_dec, w_illegal, w_load, w_at_one;
    logic [C_MIN_U_W-1:0] w_mu_ld;
    logic [C_MIN_D_W-1:0] w_md_ld;

    assign w_preset = splinker_mode_on ? C_SPR_PRESET : C_DRIP_PRESET;
    assign w_dec    = (state_q == ST_RUN) && tick;

    // A borrow out of the minutes-tens digit means the count ran below
    // 00:00, which is treated like any other corrupted digit.
    assign w_illegal = (w_su > C_SEC_U_W'(C_SEC_U_MAX)) ||
                       (w_sd > C_SEC_D_W'(C_SEC_D_MAX)) ||
                       (w_mu > C_MIN_U_W'(C_MIN_U_MAX)) ||
                       w_md_borrow;

    // Registers load the preset in LOAD and zero in DONE; a corrupted
    // value seen in RUN is cleared on the same edge that enters DONE.
    assign w_load  = (state_q != ST_RUN) || w_illegal;
    assign w_mu_ld = (state_q == ST_LOAD) ? w_preset.units : '0;
    assign w_md_ld = (state_q == ST_LOAD) ? w_preset.tens  : '0;

    assign w_at_one = (w_su == C_SEC_U_W'(1)) && (w_sd == '0) &&
                      (w_mu == '0) && (w_md == '0);

    bcd_down_digit #(.WIDTH(C_SEC_U_W), .MAX(C_SEC_U_MAX)) u_sec_u (
        .clock(clock), .reset(reset), .load(w_load), .load_val('0),
        .borrow_in(w_dec), .value(w_su), .borrow_out(w_su_borrow)
    );
    bcd_down_digit #(.WIDTH(C_SEC_D_W), .MAX(C_SEC_D_MAX)) u_sec_d (
        .clock(clock), .reset(reset), .load(w_load), .load_val('0),
        .borrow_in(w_su_borrow), .value(w_sd), .borrow_out(w_sd_borrow)
    );
    bcd_down_digit #(.WIDTH(C_MIN_U_W), .MAX(C_MIN_U_MAX)) u_min_u (
        .clock(clock), .reset(reset), .load(w_load), .load_val(w_mu_ld),
        .borrow_in(w_sd_borrow), .value(w_mu), .borrow_out(w_mu_borrow)
    );
    bcd_down_digit #(.WIDTH(C_MIN_D_W), .MAX(C_MIN_D_MAX)) u_min_d (
        .clock(clock), .reset(reset), .load(w_load), .load_val(w_md_ld),
        .borrow_in(w_mu_borrow), .value(w_md), .borrow_out(w_md_borrow)
    );

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_LOAD;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic. LOAD always leaves after one edge; the decrement is
    // gated by state_q == ST_RUN so a tick on that edge is ignored.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            ST_LOAD: state_d = ST_RUN;
            ST_RUN: begin
                if (w_illegal) begin
                    state_d = ST_DONE;
                end else if (tick && w_at_one) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_DONE;
        endcase
    end

    // Outputs. In LOAD the digits bypass the registers so the live mode
    // preset is visible while reset is still held.
    always_comb begin
        running = (state_q == ST_RUN);
        done    = done_q;
        if (state_q == ST_LOAD) begin
            seconds_u = '0;
            seconds_d = '0;
            minutes_u = w_preset.units;
            minutes_d = w_preset.tens;
        end else begin
            seconds_u = w_su;
            seconds_d = w_sd;
            minutes_u = w_mu;
            minutes_d = w_md;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_irrigation_countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_irrigation_countdown_timer
//  Purpose  : Directed self-checking bench for irrigation_countdown_timer
//             with default parameters (sprinkler 05:00, drip 30:00).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_irrigation_countdown_timer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       splinker_mode_on = 1'b1;
    logic [3:0] seconds_u;
    logic [2:0] seconds_d;
    logic [3:0] minutes_u;
    logic [1:0] minutes_d;
    logic       running;
    logic       done;

    int errors = 0;
    int checks = 0;
    int done_seen = 0;

    irrigation_countdown_timer dut (
        .clock            (clock),
        .reset            (reset),
        .tick             (tick),
        .splinker_mode_on (splinker_mode_on),
        .seconds_u        (seconds_u),
        .seconds_d        (seconds_d),
        .minutes_u        (minutes_u),
        .minutes_d        (minutes_d),
        .running          (running),
        .done             (done)
    );

    always #5 clock = ~clock;

    // Digits packed as hex mm:ss, e.g. 16'h0459 reads 04:59
    function automatic logic [15:0] mmss();
        return {2'b00, minutes_d, minutes_u, 1'b0, seconds_d, seconds_u};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance n clocks, sampling 1 time unit after each rising edge
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            if (done === 1'b1) done_seen++;
        end
    endtask

    // n ticks, each one clock wide followed by one idle clock
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            cyc(1);
            tick = 1'b0;
            cyc(1);
        end
    endtask

    initial begin
        // Reset held, sprinkler mode
        cyc(2);
        chk("rst_digits", mmss(), 16'h0500);
        chk("rst_running", 16'(running), 16'h0);
        chk("rst_done", 16'(done), 16'h0);

        // Release: first edge enters RUN without decrement
        reset = 1'b0;
        cyc(1);
        chk("run_entry_digits", mmss(), 16'h0500);
        chk("run_entry_running", 16'(running), 16'h1);
        done_seen = 0;
        ticks(1);
        chk("first_tick", mmss(), 16'h0459);

        // Sprinkler to completion
        ticks(298);
        chk("spr_0001", mmss(), 16'h0001);
        chk("spr_no_early_done", 16'(done_seen), 16'h0);
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        chk("spr_zero", mmss(), 16'h0000);
        chk("spr_done_pulse", 16'(done), 16'h1);
        chk("spr_done_running", 16'(running), 16'h0);
        cyc(1);
        chk("spr_done_cleared", 16'(done), 16'h0);
        ticks(10);
        chk("spr_hold_zero", mmss(), 16'h0000);
        chk("spr_done_count", 16'(done_seen), 16'h1);
        chk("spr_hold_running", 16'(running), 16'h0);

        // Drip mode, borrows across every digit
        #3;
        splinker_mode_on = 1'b0;
        reset = 1'b1;
        #1;
        chk("drip_async_preset", mmss(), 16'h3000);
        chk("drip_rst_running", 16'(running), 16'h0);
        cyc(2);
        chk("drip_held", mmss(), 16'h3000);
        reset = 1'b0;
        cyc(1);
        chk("drip_run_entry", 16'(running), 16'h1);
        done_seen = 0;
        ticks(1);
        chk("drip_2959", mmss(), 16'h2959);
        ticks(50);
        chk("drip_2909", mmss(), 16'h2909);
        ticks(10);
        chk("drip_2859", mmss(), 16'h2859);
        ticks(480);
        chk("drip_2059", mmss(), 16'h2059);
        ticks(60);
        chk("drip_1959", mmss(), 16'h1959);
        ticks(445);
        chk("drip_1234", mmss(), 16'h1234);
        chk("drip_1234_running", 16'(running), 16'h1);

        // Asynchronous reset mid-run, between edges
        #3;
        reset = 1'b1;
        #1;
        chk("midrst_preset", mmss(), 16'h3000);
        chk("midrst_running", 16'(running), 16'h0);
        chk("midrst_done", 16'(done), 16'h0);
        cyc(3);
        chk("midrst_no_done", 16'(done_seen), 16'h0);

        // Live mode select while in LOAD, then mode change during RUN
        splinker_mode_on = 1'b1;
        #1;
        chk("load_live_mode", mmss(), 16'h0500);
        reset = 1'b0;
        cyc(1);
        ticks(110);
        chk("mode_0310", mmss(), 16'h0310);
        splinker_mode_on = 1'b0;
        cyc(1);
        chk("mode_toggle_hold", mmss(), 16'h0310);
        ticks(1);
        chk("mode_toggle_0309", mmss(), 16'h0309);
        #3;
        reset = 1'b1;
        #1;
        chk("mode_new_preset", mmss(), 16'h3000);

        // Tick coincident with the LOAD->RUN edge, then a long idle stretch
        tick = 1'b1;
        reset = 1'b0;
        cyc(1);
        tick = 1'b0;
        chk("coinc_tick_digits", mmss(), 16'h3000);
        chk("coinc_tick_running", 16'(running), 16'h1);
        cyc(100);
        chk("idle_hold", mmss(), 16'h3000);
        ticks(1);
        chk("idle_then_tick", mmss(), 16'h2959);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
